// File: rtl/mips_pkg.sv
// Shared widths, constants and fetch FSM encoding for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] WORD_INC = 32'd4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular prefetch buffer with flush; the head entry is read combinationally.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only observed once count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch PC owner and memory request FSM feeding the IF/ID register through a prefetch FIFO.
module if_prefetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] next_inst_adr
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fetch_state_e               state_q, state_d;
  logic [ADDR_W-1:0]          fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]          req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]          seq_addr;
  logic [CntW-1:0]            count;
  logic [CntW-1:0]            count_after;
  logic [INST_W+ADDR_W-1:0]   head;
  logic                       push;
  logic                       pop;

  assign seq_addr = req_addr_q + WORD_INC;
  assign pop      = inst_valid & ~stall & ~redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    push        = 1'b0;
    // Occupancy as seen after this cycle's pop (and push, once known).
    count_after = count - CntW'(pop);
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (count_after < Full) begin
          req_addr_d = fetch_pc_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_ack ? StIdle : StDrop;
        end else if (imem_ack) begin
          push        = 1'b1;
          fetch_pc_d  = seq_addr;
          count_after = count_after + 1'b1;
          if (count_after < Full) req_addr_d = seq_addr;
          else                    state_d    = StIdle;
        end
      end
      StDrop: begin
        // Stale request stays on the bus until memory answers it.
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({imem_rdata, seq_addr}),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_req      = (state_q != StIdle);
  assign imem_addr     = req_addr_q;
  assign inst_valid    = (count != '0);
  assign inst          = head[INST_W+ADDR_W-1:ADDR_W];
  assign next_inst_adr = head[ADDR_W-1:0];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised and directed bench for if_prefetch_queue against a queue-based fetch model.
module tb_if_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] next_inst_adr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: buffered {inst, pc+4} pairs plus the single outstanding request.
  logic [63:0] mq[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_addr;
  bit          m_out;
  bit          m_stale;

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .next_inst_adr (next_inst_adr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch_pc = RESET_PC;
    m_req_addr = RESET_PC;
    m_out      = 1'b0;
    m_stale    = 1'b0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] rpc, input bit ack,
                            input logic [31:0] rdata, input bit stl);
    bit pop;
    pop = (mq.size() != 0) && !stl && !redir;
    if (redir) begin
      mq.delete();
      m_fetch_pc = rpc;
      m_out      = m_out && !ack;
      m_stale    = m_out;
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_out) begin
        if (mq.size() < DEPTH) begin
          m_out      = 1'b1;
          m_stale    = 1'b0;
          m_req_addr = m_fetch_pc;
        end
      end else if (ack) begin
        if (m_stale) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          mq.push_back({rdata, m_req_addr + 32'd4});
          m_fetch_pc = m_req_addr + 32'd4;
          if (mq.size() < DEPTH) m_req_addr = m_req_addr + 32'd4;
          else                   m_out      = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("imem_req", 32'(imem_req), 32'(m_out));
    check("imem_addr", imem_addr, m_req_addr);
    check("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("inst", inst, mq[0][63:32]);
      check("next_inst_adr", next_inst_adr, mq[0][31:0]);
    end
  endtask

  // Called at a falling edge: check, drive inputs, advance the model, step one clock.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit ack, input bit stl);
    compare_outputs();
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = ack;
    stall       = stl;
    imem_rdata  = inst_of(imem_addr);
    model_step(redir, rpc, ack, imem_rdata, stl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rd, ak, st;

    // Zero-wait memory from reset.
    do_reset();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_valid", 32'(inst_valid), 32'd1);
    check("t1_inst", inst, inst_of(32'h0));
    check("t1_next", next_inst_adr, 32'h4);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_addr8", imem_addr, 32'h8);

    // Stall held: fills to DEPTH then stops; release resumes at 16.
    do_reset();
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_head", inst, inst_of(32'h0));
    check("t2_next", next_inst_adr, 32'h4);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t2_resume_req", 32'(imem_req), 32'd1);
    check("t2_resume_addr", imem_addr, 32'h10);
    check("t2_pop1", next_inst_adr, 32'h8);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t2_pop2", next_inst_adr, 32'hC);

    // Redirect while waiting; stale ack three cycles later is dropped.
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b1);
    check("t3_drop_req", 32'(imem_req), 32'd1);
    check("t3_drop_addr", imem_addr, 32'h0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_drop_hold", imem_addr, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t3_discard", 32'(inst_valid), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_new_addr", imem_addr, 32'h100);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t3_head", inst, inst_of(32'h100));
    check("t3_next", next_inst_adr, 32'h104);

    // Redirect coincident with ack and pop.
    do_reset();
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h200, 1'b1, 1'b0);
    check("t4_flushed", 32'(inst_valid), 32'd0);
    check("t4_idle", 32'(imem_req), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t4_addr", imem_addr, 32'h200);

    // Address wrap past the top of memory.
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t5_addr_f8", imem_addr, 32'hFFFF_FFF8);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t5_addr_fc", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t5_addr_wrap", imem_addr, 32'h0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t5_next_wrap", next_inst_adr, 32'h0);

    // Asynchronous reset between clock edges.
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t6_req_async", 32'(imem_req), 32'd0);
    check("t6_valid_async", 32'(inst_valid), 32'd0);
    check("t6_addr_async", imem_addr, RESET_PC);
    imem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t6_restart", imem_addr, RESET_PC);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rd  = ($urandom_range(0, 99) < 6);
      ak  = ($urandom_range(0, 99) < 55);
      st  = ($urandom_range(0, 99) < 35);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      cycle(rd, rpc, ak, st);
    end
    compare_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register of the pipelined MIPS core. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch FIFO and presented to IF/ID as {instruction, PC+4} pairs. It honours decode-stage stalls and branch/jump redirects, including discarding an in-flight fetch made stale by a redirect.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word address of the current request
imem_ack  input  1  memory accepts the request and returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  new fetch address, valid with redirect
stall  input  1  IF/ID not writing this cycle (hazard unit IRWrite low)
inst_valid  output  1  FIFO head valid
inst  output  32  FIFO head instruction
next_inst_adr  output  32  FIFO head fetch address + 4

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, rd_ptr=wr_ptr=0, count=0. Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0; inst and next_inst_adr are don't-care (driven from RAM head).
- Outputs imem_req=(state!=IDLE), imem_addr=req_addr (registered), inst_valid=(count!=0), inst/next_inst_adr=head entry (combinational read).
- Handshake: once imem_req=1, imem_addr is held stable until the cycle with imem_ack=1; at most one request is outstanding. imem_ack while imem_req=0 is ignored.
- FSM states:
  IDLE: if redirect, fetch_pc<=redirect_pc and stay. Else if count<DEPTH (after this cycle's pop), req_addr<=fetch_pc and go to WAIT.
  WAIT: if redirect, then (a) with ack: discard data, fetch_pc<=redirect_pc, go to IDLE; (b) without ack: fetch_pc<=redirect_pc, go to DROP.
  WAIT, no redirect, ack: push {imem_rdata, req_addr+4}; fetch_pc<=req_addr+4. If post-push/post-pop count<DEPTH, req_addr<=req_addr+4 and stay in WAIT (back-to-back, 1 word/cycle peak). Otherwise go to IDLE.
  DROP: request stays asserted at the stale address. On ack: discard data and go to IDLE. A redirect in DROP updates fetch_pc only.
- Pop: when inst_valid=1 and stall=0 and redirect=0, rd_ptr advances.
- Redirect: the FIFO is flushed (rd_ptr=wr_ptr, count=0) in the same edge. Redirect has priority over push and pop in the same cycle.
- Push and pop in the same cycle: count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- An issued request always has a free slot, so FIFO overflow is impossible by construction. Push is never attempted when full.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0. Low two address bits pass through unchecked.
- Stall holds the head stable indefinitely. Fetching continues until the FIFO is full.

Decomposition:
- Shared package mips_pkg: ADDR_W=32, INST_W=32, WORD_INC=4, fetch FSM state enum {IDLE, WAIT, DROP}.
- One sub-module, prefetch_fifo (parameterised DEPTH × 64-bit, with flush, push, pop, count, head read). The FSM and PC logic live in the top.

Test Plan:
- Release reset, zero-wait memory (ack same cycle as req): first imem_req at cycle 1 with addr 0. Then addr 4, 8, 12 back-to-back. Head reads inst(0), next_inst_adr=4, inst_valid=1 one cycle after the first ack.
- stall=1 held, zero-wait memory: exactly 4 pushes (addr 0..12), then imem_req=0. Release stall: pops of 0, 4, 8, 12 in order and fetching resumes at 16.
- Redirect to 32'h100 while WAIT with ack delayed 3 cycles: FSM enters DROP, addr stays at the old value until ack, and that data is discarded. The next request is 32'h100, and the head after the refill is inst(0x100) with next_inst_adr=0x104.
- Redirect coincident with ack and a pop: FIFO count=0 next cycle, no push of the returned word, next request at redirect_pc.
- Fetch from 32'hFFFF_FFF8: next addresses FFFF_FFFC then 0000_0000. next_inst_adr=0 for the FFFF_FFFC entry.
- Assert rst=0 asynchronously mid-WAIT (between clock edges): imem_req drops immediately, inst_valid=0. After release, fetching restarts at RESET_PC.
